// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: host byte bus plus UART send/receive handshake signals for uart_ctrl.
interface uart_ctrl_if;
  logic       iWR;
  logic [7:0] iWDATA;
  logic       iRD;
  logic [7:0] oRDATA;
  logic       oTX_FULL;
  logic       oTX_IDLE;
  logic       oRX_EMPTY;
  logic       oRX_OVF;
  logic       iCLR_OVF;
  logic       oUT;
  logic [7:0] oUTDATA;
  logic       iUT;
  logic       iUR;
  logic [7:0] iURDATA;
  modport master (
    output iWR, iWDATA, iRD, iCLR_OVF, iUT, iUR, iURDATA,
    input  oRDATA, oTX_FULL, oTX_IDLE, oRX_EMPTY, oRX_OVF, oUT, oUTDATA
  );
  modport slave (
    input  iWR, iWDATA, iRD, iCLR_OVF, iUT, iUR, iURDATA,
    output oRDATA, oTX_FULL, oTX_IDLE, oRX_EMPTY, oRX_OVF, oUT, oUTDATA
  );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: TX/RX byte FIFOs between a host strobe bus and a level-handshake UART.
module uart_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic      iCLK,
  input logic      iRST_N,
  uart_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, REQ, BUSY, GAP} tx_state_t;
  tx_state_t state, stateNxt;
  logic [7:0] txMem [DEPTH];
  logic [7:0] rxMem [DEPTH];
  ptr_t txWp, txRp, rxWp, rxRp;
  cnt_t txCnt, rxCnt;
  logic [7:0] utData;
  logic tmr, txPop, txPush, urD, rxCap, rxPop, rxPush, rxOvf;
  always_comb begin
    stateNxt = state;
    txPop    = 1'b0;
    case (state)
      IDLE: if (txCnt != '0 && bus.iUT) begin
        stateNxt = LOAD;
        txPop    = 1'b1;
      end
      LOAD:    stateNxt = tmr ? REQ : LOAD;
      REQ:     stateNxt = bus.iUT ? REQ : BUSY;
      BUSY:    stateNxt = bus.iUT ? GAP : BUSY;
      GAP:     stateNxt = tmr ? IDLE : GAP;
      default: stateNxt = IDLE;
    endcase
  end
  // A simultaneous pop frees the slot, so a write to a full FIFO still lands
  assign txPush = bus.iWR && (txCnt != FULL || txPop);
  assign rxCap  = bus.iUR && !urD;
  assign rxPop  = bus.iRD && rxCnt != '0;
  assign rxPush = rxCap && (rxCnt != FULL || rxPop);
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      tmr    <= 1'b0;
      utData <= '0;
      txWp   <= '0;
      txRp   <= '0;
      txCnt  <= '0;
      rxWp   <= '0;
      rxRp   <= '0;
      rxCnt  <= '0;
      urD    <= 1'b1;
      rxOvf  <= 1'b0;
    end else begin
      state  <= stateNxt;
      tmr    <= (state == LOAD || state == GAP) && !tmr;
      utData <= txPop ? txMem[txRp] : utData;
      txWp   <= txWp + ptr_t'(txPush);
      txRp   <= txRp + ptr_t'(txPop);
      txCnt  <= txCnt + cnt_t'(txPush) - cnt_t'(txPop);
      rxWp   <= rxWp + ptr_t'(rxPush);
      rxRp   <= rxRp + ptr_t'(rxPop);
      rxCnt  <= rxCnt + cnt_t'(rxPush) - cnt_t'(rxPop);
      urD    <= bus.iUR;
      rxOvf  <= (rxCap && !rxPush) ? 1'b1 : bus.iCLR_OVF ? 1'b0 : rxOvf;
    end
  end
  always_ff @(posedge iCLK) begin
    if (txPush) txMem[txWp] <= bus.iWDATA;
    if (rxPush) rxMem[rxWp] <= bus.iURDATA;
  end
  assign bus.oRDATA    = rxMem[rxRp];
  assign bus.oTX_FULL  = txCnt == FULL;
  assign bus.oTX_IDLE  = txCnt == '0 && state == IDLE && bus.iUT;
  assign bus.oRX_EMPTY = rxCnt == '0;
  assign bus.oRX_OVF   = rxOvf;
  assign bus.oUT       = state == REQ || state == BUSY;
  assign bus.oUTDATA   = utData;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed scoreboard bench for uart_ctrl with a level-handshake UART model.
module tb_uart_ctrl;
  logic clk = 1'b0;
  logic rstN;
  logic utLvl = 1'b1;
  logic utHold = 1'b0;
  logic outPrev = 1'b0;
  logic [7:0] curByte = '0;
  int utCnt = 0;
  int txEdges = 0;
  int edgesAtReset = 0;
  int nChecks = 0;
  int nFails = 0;
  logic [7:0] txQ [$];
  logic [7:0] rxQ [$];

  uart_ctrl_if bus ();
  uart_ctrl #(.DEPTH_LOG2(4)) dut (.iCLK(clk), .iRST_N(rstN), .bus(bus));

  always #5 clk = ~clk;
  assign bus.iUT = utLvl & ~utHold;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: drops iUT 4 cycles after each oUT rise, keeps it low 100 cycles
  always @(negedge clk) begin
    if (!rstN) begin
      utLvl   = 1'b1;
      utCnt   = 0;
      outPrev = 1'b0;
    end else begin
      if (bus.oUT && !outPrev) begin
        txEdges++;
        curByte = bus.oUTDATA;
        chk("tx_byte", {1'b0, bus.oUTDATA}, txQ.size() != 0 ? {1'b0, txQ.pop_front()} : 9'h100);
        utCnt = 1;
      end else if (utCnt != 0) begin
        utCnt++;
        if (utCnt == 5) begin
          chk("tx_data_stable", {1'b0, bus.oUTDATA}, {1'b0, curByte});
          utLvl = 1'b0;
        end
        if (utCnt == 105) begin
          chk("tx_busy_out", {8'h0, bus.oUT}, 9'h1);
          utLvl = 1'b1;
          utCnt = 0;
        end
      end
      outPrev = bus.oUT;
    end
  end

  task automatic wrByte(input logic [7:0] b);
    bus.iWR = 1'b1;
    bus.iWDATA = b;
    txQ.push_back(b);
    @(negedge clk);
    bus.iWR = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    repeat (3) @(negedge clk);
    while (!(bus.oTX_IDLE && utCnt == 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {8'h0, n < 5000}, 9'h1);
  endtask

  task automatic capture(input logic [7:0] b, input logic keep);
    bus.iURDATA = b;
    bus.iUR = 1'b0;
    @(negedge clk);
    bus.iUR = 1'b1;
    if (keep) rxQ.push_back(b);
    @(negedge clk);
  endtask

  task automatic rdByte(input string tag);
    chk(tag, {1'b0, bus.oRDATA}, rxQ.size() != 0 ? {1'b0, rxQ.pop_front()} : 9'h100);
    bus.iRD = 1'b1;
    @(negedge clk);
    bus.iRD = 1'b0;
  endtask

  initial begin
    int n;
    rstN = 1'b0;
    bus.iWR = 1'b0;
    bus.iWDATA = '0;
    bus.iRD = 1'b0;
    bus.iCLR_OVF = 1'b0;
    bus.iUR = 1'b1;
    bus.iURDATA = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_full", {8'h0, bus.oTX_FULL}, 9'h0);
    chk("rst_rx_empty", {8'h0, bus.oRX_EMPTY}, 9'h1);
    chk("rst_tx_idle", {8'h0, bus.oTX_IDLE}, 9'h1);
    chk("rst_out", {8'h0, bus.oUT}, 9'h0);
    chk("rst_outdata", {1'b0, bus.oUTDATA}, 9'h0);
    chk("rst_ovf", {8'h0, bus.oRX_OVF}, 9'h0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_release_no_cap", {8'h0, bus.oRX_EMPTY}, 9'h1);

    wrByte(8'h55);
    waitIdle("single_idle");
    chk("single_edges", 9'(txEdges), 9'd1);
    chk("single_tx_idle", {8'h0, bus.oTX_IDLE}, 9'h1);

    utHold = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      bus.iWR = 1'b1;
      bus.iWDATA = 8'(i);
      if (i <= 16) txQ.push_back(8'(i));
      @(negedge clk);
      if (i == 15) chk("burst_not_full_15", {8'h0, bus.oTX_FULL}, 9'h0);
      if (i == 16) chk("burst_full_16", {8'h0, bus.oTX_FULL}, 9'h1);
    end
    bus.iWR = 1'b0;
    chk("burst_full_17", {8'h0, bus.oTX_FULL}, 9'h1);
    utHold = 1'b0;
    waitIdle("burst_idle");
    chk("burst_edges", 9'(txEdges), 9'd17);
    chk("burst_q_drained", 9'(txQ.size()), 9'd0);

    capture(8'hA0, 1'b1);
    chk("rx_not_empty", {8'h0, bus.oRX_EMPTY}, 9'h0);
    capture(8'hA1, 1'b1);
    capture(8'hA2, 1'b1);
    repeat (3) rdByte("rx_read");
    chk("rx_empty_after", {8'h0, bus.oRX_EMPTY}, 9'h1);

    bus.iRD = 1'b1;
    @(negedge clk);
    bus.iRD = 1'b0;
    capture(8'h33, 1'b1);
    rdByte("rx_after_empty_rd");
    chk("rx_empty_again", {8'h0, bus.oRX_EMPTY}, 9'h1);

    for (int i = 0; i < 16; i++) capture(8'h10 + 8'(i), 1'b1);
    chk("ovf_not_yet", {8'h0, bus.oRX_OVF}, 9'h0);
    capture(8'hEE, 1'b0);
    chk("ovf_set", {8'h0, bus.oRX_OVF}, 9'h1);
    bus.iCLR_OVF = 1'b1;
    @(negedge clk);
    bus.iCLR_OVF = 1'b0;
    chk("ovf_cleared", {8'h0, bus.oRX_OVF}, 9'h0);

    bus.iUR = 1'b0;
    bus.iURDATA = 8'h7E;
    @(negedge clk);
    chk("simul_rd_head", {1'b0, bus.oRDATA}, {1'b0, rxQ.pop_front()});
    bus.iUR = 1'b1;
    bus.iRD = 1'b1;
    rxQ.push_back(8'h7E);
    @(negedge clk);
    bus.iRD = 1'b0;
    chk("simul_no_ovf", {8'h0, bus.oRX_OVF}, 9'h0);
    for (int i = 0; i < 15; i++) rdByte("drain_read");
    chk("drain_one_left", {8'h0, bus.oRX_EMPTY}, 9'h0);
    rdByte("drain_last_7e");
    chk("drain_empty", {8'h0, bus.oRX_EMPTY}, 9'h1);

    for (int i = 0; i < 6; i++) wrByte(8'hC0 + 8'(i));
    n = 0;
    while (utLvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_reached", {8'h0, n < 200}, 9'h1);
    repeat (5) @(negedge clk);
    bus.iUR = 1'b0;
    rstN = 1'b0;
    txQ.delete();
    edgesAtReset = txEdges;
    repeat (3) @(negedge clk);
    chk("midrst_out", {8'h0, bus.oUT}, 9'h0);
    chk("midrst_tx_idle", {8'h0, bus.oTX_IDLE}, 9'h1);
    bus.iUR = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_edges", 9'(txEdges - edgesAtReset), 9'd0);
    chk("midrst_out_low", {8'h0, bus.oUT}, 9'h0);
    chk("midrst_idle_after", {8'h0, bus.oTX_IDLE}, 9'h1);
    chk("midrst_no_capture", {8'h0, bus.oRX_EMPTY}, 9'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
